// File: rtl/fix_phase_nco.sv
// fix_phase_nco: burst phase-accumulator feeding a FixSinCos unit.
// Emits Q1.Precision angles on x_o, a matching x_valid_o strobe, and a
// res_valid_o strobe delayed by the downstream unit's Latency.
// Optional feature macro: FIX_NCO_DITHER_EN (LSB dither from a 16-bit LFSR).
module fix_phase_nco #(
    parameter int Precision  = 24,
    parameter int Width      = Precision + 1,
    parameter int Latency    = 2,
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [Width-1:0]      cfg_phase0_i,
    input  logic [Width-1:0]      cfg_incr_i,
    input  logic [CountWidth-1:0] cfg_count_i,
    input  logic                  halt_i,
    input  logic                  abort_i,
    output logic [Width-1:0]      x_o,
    output logic                  x_valid_o,
    output logic                  res_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    // Angle format is Q1.Precision; a mismatch would silently misscale angles.
    if (Width != Precision + 1 || Latency < 1 || Latency > 4) begin : g_bad_cfg
        $error("fix_phase_nco: unsupported Width/Precision/Latency combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [Width-1:0] phase_q;
    logic signed [Width-1:0] incr_q;
    logic [CountWidth-1:0]   remaining_q;
    logic [2:0]              drain_cnt_q;
    logic [Latency-1:0]      vld_pipe;
    logic                    done_q;

    logic cfg_fire;
    logic cfg_zero;
    logic emit;
    logic last_emit;
    logic drain_last;

    // Width-bit wrapping add: carry out is dropped, so +1 rolls over to -1.
    function automatic logic signed [Width-1:0] phase_add(
        input logic signed [Width-1:0] a,
        input logic signed [Width-1:0] b
    );
        phase_add = a + b;
    endfunction

    assign cfg_fire   = (state_q == IDLE) && cfg_valid_i;
    assign cfg_zero   = (cfg_count_i == '0);
    assign emit       = (state_q == RUN) && !halt_i;
    assign last_emit  = emit && (remaining_q == CountWidth'(1));
    assign drain_last = (state_q == DRAIN) && (drain_cnt_q == 3'(Latency - 1));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; abort ends the burst but the sample of that cycle still goes out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_fire && !cfg_zero) state_d = RUN;
            RUN:     if (abort_i || last_emit)  state_d = DRAIN;
            DRAIN:   if (drain_last)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase accumulator, increment and remaining-sample counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q     <= '0;
            incr_q      <= '0;
            remaining_q <= '0;
        end else if (cfg_fire && !cfg_zero) begin
            phase_q     <= $signed(cfg_phase0_i);
            incr_q      <= $signed(cfg_incr_i);
            remaining_q <= cfg_count_i;
        end else if (emit) begin
            phase_q     <= phase_add(phase_q, incr_q);
            remaining_q <= remaining_q - CountWidth'(1);
        end
    end

    // Drain timer: counts the cycles spent in DRAIN so the delay line empties.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                  drain_cnt_q <= '0;
        else if (state_q != DRAIN)  drain_cnt_q <= '0;
        else                        drain_cnt_q <= drain_cnt_q + 3'd1;
    end

    // Valid delay line matching the downstream FixSinCos latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= emit;
            for (int i = 1; i < Latency; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Completion pulse: end of drain, or an accepted zero-length burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) done_q <= 1'b0;
        else       done_q <= (cfg_fire && cfg_zero) || drain_last;
    end

`ifdef FIX_NCO_DITHER_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        lfsr_next = {fb, s[15:1]};
    endfunction

    // Dither sequence restarts with every burst and steps once per emitted sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         lfsr_q <= 16'hACE1;
        else if (cfg_fire) lfsr_q <= 16'hACE1;
        else if (emit)     lfsr_q <= lfsr_next(lfsr_q);
    end

    // Only the presented angle is dithered; outside RUN x_o shows the plain phase.
    assign x_o = phase_q ^ {{(Width-1){1'b0}}, lfsr_q[0] & (state_q == RUN)};
`else
    assign x_o = phase_q;
`endif

    assign x_valid_o   = emit;
    assign res_valid_o = vld_pipe[Latency-1];
    assign busy_o      = (state_q != IDLE);
    assign cfg_ready_o = (state_q == IDLE);
    assign done_o      = done_q;

endmodule
